// File: rtl/mtr_drv_pkg.sv
// Shared constants and helpers for the motor-drive PWM path.
package mtr_drv_pkg;

  localparam int DUTY_W = 11;

  typedef logic [DUTY_W-1:0] duty_t;
  typedef logic signed [11:0] spd_t;

  localparam duty_t      NONOVERLAP = 11'h020;
  localparam duty_t      BLANK      = 11'd128;
  localparam duty_t      DUTY_MID   = 11'h400;
  localparam logic [2:0] OVR_LIMIT  = 3'd4;

  // Clamp a signed speed command to [-1024,+1023] and offset it to an unsigned duty.
  function automatic duty_t spd_to_duty(input spd_t spd);
    spd_t sat;
    if (spd > 12'sd1023)       sat = 12'sd1023;
    else if (spd < -12'sd1024) sat = -12'sd1024;
    else                       sat = spd;
    return sat[DUTY_W-1:0] + DUTY_MID;
  endfunction

endpackage

// File: rtl/PWM11.sv
// One H-bridge side: high/low drives from the shared counter and a latched duty,
// with a guaranteed dead band between them.
module PWM11
  import mtr_drv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] i_cnt,
  input  logic [DUTY_W-1:0] i_duty,
  input  logic              i_en,
  output logic              o_pwm1,
  output logic              o_pwm2
);

  logic [DUTY_W:0] w_lo_start;
  logic            w_pwm1;
  logic            w_pwm2;
  logic            r_pwm1;
  logic            r_pwm2;

  // One extra bit so a start point beyond 2047 simply never matches.
  assign w_lo_start = {1'b0, i_duty} + {1'b0, NONOVERLAP};
  assign w_pwm1     = i_en && (i_cnt >= NONOVERLAP) && (i_cnt < i_duty);
  assign w_pwm2     = i_en && ({1'b0, i_cnt} >= w_lo_start);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm1 <= 1'b0;
      r_pwm2 <= 1'b0;
    end else begin
      r_pwm1 <= w_pwm1;
      r_pwm2 <= w_pwm2;
    end
  end

  assign o_pwm1 = r_pwm1;
  assign o_pwm2 = r_pwm2;

endmodule

// File: rtl/mtr_drv.sv
// Dual H-bridge motor driver: shared 11-bit PWM period, speed saturation,
// period-aligned duty latching and consecutive-period over-current shutdown.
module mtr_drv
  import mtr_drv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic               OVR_I_lft,
  input  logic               OVR_I_rght,
  output logic               PWM1_lft,
  output logic               PWM2_lft,
  output logic               PWM1_rght,
  output logic               PWM2_rght,
  output logic               PWM_synch,
  output logic               OVR_I_shtdwn
);

  logic [DUTY_W-1:0] r_cnt;
  logic              r_synch;
  duty_t             r_duty_lft;
  duty_t             r_duty_rght;
  logic              r_ovr_seen;
  logic [2:0]        r_ovr_cnt;
  logic              r_shtdwn;

  logic              w_period_start;
  logic              w_ovr_evt;
  logic [2:0]        w_ovr_cnt_nxt;
  logic              w_pwm_en;

  assign w_period_start = (r_cnt == '0);
  assign w_ovr_evt      = (OVR_I_lft | OVR_I_rght) && (r_cnt >= BLANK);
  assign w_ovr_cnt_nxt  = !r_ovr_seen        ? 3'd0      :
                          (r_ovr_cnt == 3'd7) ? r_ovr_cnt : r_ovr_cnt + 3'd1;
  assign w_pwm_en       = !r_shtdwn;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_synch <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + 11'd1;
      // Registered so the pulse lines up with cnt==0; reset already covers the
      // very first period, so no pulse is needed while reset holds cnt at 0.
      r_synch <= (r_cnt == '1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_lft  <= DUTY_MID;
      r_duty_rght <= DUTY_MID;
    end else if (w_period_start) begin
      r_duty_lft  <= spd_to_duty(lft_spd);
      r_duty_rght <= spd_to_duty(rght_spd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr_seen <= 1'b0;
      r_ovr_cnt  <= 3'd0;
      r_shtdwn   <= 1'b0;
    end else if (w_period_start) begin
      r_ovr_cnt  <= w_ovr_cnt_nxt;
      r_ovr_seen <= w_ovr_evt;
      if (w_ovr_cnt_nxt >= OVR_LIMIT) r_shtdwn <= 1'b1;
    end else if (w_ovr_evt) begin
      r_ovr_seen <= 1'b1;
    end
  end

  PWM11 u_pwm_lft (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_cnt  (r_cnt),
    .i_duty (r_duty_lft),
    .i_en   (w_pwm_en),
    .o_pwm1 (PWM1_lft),
    .o_pwm2 (PWM2_lft)
  );

  PWM11 u_pwm_rght (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_cnt  (r_cnt),
    .i_duty (r_duty_rght),
    .i_en   (w_pwm_en),
    .o_pwm1 (PWM1_rght),
    .o_pwm2 (PWM2_rght)
  );

  assign PWM_synch    = r_synch;
  assign OVR_I_shtdwn = r_shtdwn;

endmodule

// File: tb/tb_mtr_drv.sv
// Scoreboarded bench for mtr_drv: a cycle model feeds expected outputs into a
// queue, and per-period window statistics check the PWM edges directly.
module tb_mtr_drv;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [11:0] lft_spd = '0;
  logic signed [11:0] rght_spd = '0;
  logic               OVR_I_lft = 1'b0;
  logic               OVR_I_rght = 1'b0;
  logic               PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght;
  logic               PWM_synch, OVR_I_shtdwn;

  always #5 clk = ~clk;

  mtr_drv dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .OVR_I_lft    (OVR_I_lft),
    .OVR_I_rght   (OVR_I_rght),
    .PWM1_lft     (PWM1_lft),
    .PWM2_lft     (PWM2_lft),
    .PWM1_rght    (PWM1_rght),
    .PWM2_rght    (PWM2_rght),
    .PWM_synch    (PWM_synch),
    .OVR_I_shtdwn (OVR_I_shtdwn)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] dut_vec();
    return {PWM_synch, OVR_I_shtdwn, PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght};
  endfunction

  // ---------------- reference model + scoreboard ----------------
  function automatic logic [10:0] ref_duty(input logic signed [11:0] spd);
    int s;
    s = spd;
    if (s > 1023)  s = 1023;
    if (s < -1024) s = -1024;
    return 11'(s + 1024);
  endfunction

  function automatic logic [1:0] ref_pwm(input int c, input int duty);
    logic [1:0] p;
    p[1] = (duty > 32) && (c >= 32) && (c < duty);
    p[0] = (duty + 32 <= 2047) && (c >= duty + 32);
    return p;
  endfunction

  logic [5:0]  q_exp[$];
  int          m_cnt = 0;
  logic [10:0] m_dl = 11'h400;
  logic [10:0] m_dr = 11'h400;
  bit          m_seen = 0;
  int          m_ocnt = 0;
  bit          m_sd = 0;

  task automatic model_step();
    logic [1:0] pl, pr;
    bit         e_sync;
    if (!rst_n) begin
      m_cnt = 0; m_dl = 11'h400; m_dr = 11'h400;
      m_seen = 0; m_ocnt = 0; m_sd = 0;
      q_exp.delete();
      return;
    end
    pl     = m_sd ? 2'b00 : ref_pwm(m_cnt, int'(m_dl));
    pr     = m_sd ? 2'b00 : ref_pwm(m_cnt, int'(m_dr));
    e_sync = (m_cnt == 2047);
    if (m_cnt == 0) begin
      m_dl   = ref_duty(lft_spd);
      m_dr   = ref_duty(rght_spd);
      m_ocnt = m_seen ? m_ocnt + 1 : 0;
      if (m_ocnt >= 4) m_sd = 1;
      m_seen = 0;
    end else if ((OVR_I_lft || OVR_I_rght) && m_cnt >= 128) begin
      m_seen = 1;
    end
    m_cnt = (m_cnt + 1) % 2048;
    q_exp.push_back({e_sync, m_sd, pl, pr});
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) check("rst_out", dut_vec(), 6'h00);
    else if (q_exp.size() > 0) check("cycle", dut_vec(), q_exp.pop_front());
  end

  // ---------------- per-period window statistics ----------------
  typedef struct {int f1; int l1; int f2; int l2; int ov;} win_t;

  function automatic win_t win_clear();
    win_t w;
    w.f1 = -1; w.l1 = -1; w.f2 = -1; w.l2 = -1; w.ov = 0;
    return w;
  endfunction

  function automatic win_t win_add(input win_t w_in, input logic p1, input logic p2, input int idx);
    win_t w;
    w = w_in;
    if (p1) begin if (w.f1 < 0) w.f1 = idx; w.l1 = idx; end
    if (p2) begin if (w.f2 < 0) w.f2 = idx; w.l2 = idx; end
    if (p1 && p2) w.ov++;
    return w;
  endfunction

  win_t acc_l, acc_r, last_l, last_r;
  int   idx = 0;
  bit   last_full = 0;

  initial begin
    acc_l = win_clear(); acc_r = win_clear();
    last_l = win_clear(); last_r = win_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idx = 0; acc_l = win_clear(); acc_r = win_clear();
      end else begin
        acc_l = win_add(acc_l, PWM1_lft, PWM2_lft, idx);
        acc_r = win_add(acc_r, PWM1_rght, PWM2_rght, idx);
        if (PWM_synch) begin
          last_l = acc_l; last_r = acc_r; last_full = (idx == 2047);
          acc_l = win_clear(); acc_r = win_clear(); idx = 0;
        end else begin
          idx++;
        end
      end
    end
  end

  task automatic check_win(input string tag, input win_t w, input int f1, input int l1,
                           input int f2, input int l2);
    check({tag, "_full"}, 32'(last_full), 32'd1);
    check({tag, "_pwm1_first"}, w.f1, f1);
    check({tag, "_pwm1_last"}, w.l1, l1);
    check({tag, "_pwm2_first"}, w.f2, f2);
    check({tag, "_pwm2_last"}, w.l2, l2);
    check({tag, "_overlap"}, w.ov, 0);
  endtask

  // ---------------- stimulus ----------------
  task automatic wait_synch();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!PWM_synch && n < 5000);
    if (!PWM_synch) check("synch_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic pulse(input int at, input bit side);
    wait_synch();
    repeat (at) @(negedge clk);
    #1;
    if (side) OVR_I_rght = 1'b1;
    else      OVR_I_lft  = 1'b1;
    @(negedge clk);
    #1;
    OVR_I_lft  = 1'b0;
    OVR_I_rght = 1'b0;
  endtask

  initial begin
    #1 check("reset_vec", dut_vec(), 6'h00);
    #21 rst_n = 1'b1;

    // Zero speed on both sides: mid duty.
    wait_synch();
    check_win("spd0_l", last_l, 32'h20, 32'h3FF, 32'h420, 32'h7FF);
    check_win("spd0_r", last_r, 32'h20, 32'h3FF, 32'h420, 32'h7FF);

    // Saturation at both ends.
    lft_spd = 12'sh7FF; rght_spd = 12'sh800;
    wait_synch();
    check_win("sat_pos_l", last_l, 32'h20, 32'h7FE, -1, -1);
    check_win("sat_neg_r", last_r, -1, -1, 32'h20, 32'h7FF);

    // Mid-period speed change takes effect at the next period.
    lft_spd = '0; rght_spd = '0;
    wait_synch();
    repeat (12'h300) @(negedge clk);
    #1 lft_spd = 12'sh100;
    wait_synch();
    check_win("chg_cur_l", last_l, 32'h20, 32'h3FF, 32'h420, 32'h7FF);
    wait_synch();
    check_win("chg_next_l", last_l, 32'h20, 32'h4FF, 32'h520, 32'h7FF);
    lft_spd = '0;

    // Over-current inside the blanking window is ignored.
    repeat (5) pulse(50, 1'b0);
    wait_synch();
    repeat (3) @(negedge clk);
    check("blank_shtdwn", OVR_I_shtdwn, 1'b0);

    // Three events, a quiet period, then four consecutive events.
    repeat (3) pulse(300, 1'b0);
    wait_synch();
    check("after3_shtdwn", OVR_I_shtdwn, 1'b0);
    pulse(300, 1'b0);
    pulse(300, 1'b1);
    pulse(300, 1'b0);
    check("run3_shtdwn", OVR_I_shtdwn, 1'b0);
    pulse(300, 1'b0);
    check("run4_pending", OVR_I_shtdwn, 1'b0);
    wait_synch();
    check("run4_edge", OVR_I_shtdwn, 1'b0);
    @(negedge clk);
    #1 check("run4_shtdwn", OVR_I_shtdwn, 1'b1);
    wait_synch();
    check_win("sd_l", last_l, -1, -1, -1, -1);
    check_win("sd_r", last_r, -1, -1, -1, -1);

    // Reset during shutdown, mid-period.
    wait_synch();
    repeat (12'h123) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", dut_vec(), 6'h00);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_synch();
    check("post_rst_shtdwn", OVR_I_shtdwn, 1'b0);
    check_win("post_rst_l", last_l, 32'h20, 32'h3FF, 32'h420, 32'h7FF);
    check_win("post_rst_r", last_r, 32'h20, 32'h3FF, 32'h420, 32'h7FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mtr_drv.md
MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port lft_spd, input, 12 signed, left motor speed command from the speed/steering math stage.
REQ-004 SHALL have port rght_spd, input, 12 signed, right motor speed command.
REQ-005 SHALL have port OVR_I_lft, input, 1, left bridge over-current comparator output (asynchronous to clk, already synchronized upstream).
REQ-006 SHALL have port OVR_I_rght, input, 1, right bridge over-current comparator output.
REQ-007 SHALL have ports PWM1_lft and PWM2_lft, output, 1 each, left H-bridge high-side and low-side drives.
REQ-008 SHALL have ports PWM1_rght and PWM2_rght, output, 1 each, right H-bridge drives.
REQ-009 SHALL have port PWM_synch, output, 1, one-cycle pulse at PWM period start.
REQ-010 SHALL have port OVR_I_shtdwn, output, 1, sticky over-current shutdown flag.

Function
REQ-011 SHALL keep one free-running 11-bit period counter cnt, shared by both sides; 0..2047, wraps 2047->0 (period 2048 clocks).
REQ-012 SHALL assert PWM_synch for exactly the cycle in which cnt==0.
REQ-013 SHALL saturate each speed to [-1024,+1023]: values >+1023 -> +1023, values <-1024 -> -1024.
REQ-014 SHALL form the 11-bit duty as the saturated speed + 0x400; -1024 -> 0, 0 -> 0x400, +1023 -> 0x7FF.
REQ-015 SHALL latch both duties only in the PWM_synch cycle; speed changes mid-period take effect at the next period.
REQ-016 SHALL assert PWM1 (registered, 1-cycle latency from cnt) while NONOVERLAP <= cnt < duty.
REQ-017 SHALL assert PWM2 (registered) while cnt >= duty+NONOVERLAP; if duty+NONOVERLAP > 2047, PWM2 SHALL stay low all period.
REQ-018 SHALL never assert PWM1 and PWM2 of one side in the same cycle; each side gets a dead time of at least NONOVERLAP = 0x20 clocks.
REQ-019 SHALL never assert PWM1 when duty <= NONOVERLAP.
REQ-020 SHALL set a per-period flag ovr_seen when (OVR_I_lft | OVR_I_rght) is high while cnt >= BLANK (11'd128); assertions during blanking (cnt < 128) SHALL be ignored.
REQ-021 SHALL, in each PWM_synch cycle, increment the 3-bit counter ovr_cnt if ovr_seen else clear it to 0, then clear ovr_seen; an assertion in that same cycle SHALL count toward the new period.
REQ-022 SHALL set OVR_I_shtdwn when ovr_cnt reaches 4 (four consecutive periods with an event) and hold it until reset.
REQ-023 SHALL force all four PWM outputs low in the cycle after OVR_I_shtdwn sets, and thereafter; cnt and PWM_synch SHALL keep running.

Reset
REQ-024 SHALL on rst_n low, asynchronously, set cnt=0, duties=0x400, ovr_seen=0, ovr_cnt=0, OVR_I_shtdwn=0, all PWM outputs=0, PWM_synch=0.
REQ-025 SHALL, if reset is applied mid-period, restart the period from cnt=0 with no residual over-current history after release.

Structure
REQ-026 SHALL place NONOVERLAP (0x20), BLANK (128), OVR_LIMIT (4) and the 11-bit duty width in the shared Segway package.
REQ-027 SHALL instantiate sub-module PWM11 twice, one per side; PWM11 takes cnt and the latched duty and produces PWM1/PWM2 per REQ-016..019; the counter, saturation, latching and over-current logic stay in mtr_drv.

Verification
REQ-028 SHALL cover: lft_spd=0 -> PWM1_lft high for cnt 0x20..0x3FF, PWM2_lft high for cnt 0x420..0x7FF, with no overlap.
REQ-029 SHALL cover: lft_spd=12'h7FF (saturates to +1023) -> duty 0x7FF; PWM2_lft never high; PWM1_lft high for cnt 0x20..0x7FE.
REQ-030 SHALL cover: rght_spd=12'h800 (saturates to -1024) -> duty 0; PWM1_rght never high; PWM2_rght high for cnt 0x20..0x7FF.
REQ-031 SHALL cover: lft_spd changed from 0 to 0x100 at cnt=0x300 -> the current period still uses duty 0x400; the next period uses 0x500.
REQ-032 SHALL cover: OVR_I_lft pulsed at cnt=50 in every period -> OVR_I_shtdwn stays 0 (blanked); pulsed at cnt=300 for 3 periods, then one quiet period, then 4 periods -> shutdown only after the 4th consecutive period, all PWM outputs low.
REQ-033 SHALL cover: rst_n low during shutdown at cnt=0x123 -> all outputs 0 immediately; after release, normal PWM output with OVR_I_shtdwn=0.
